// File: rtl/mdom_scdb_hdr_serializer_if.sv
// ---------------------------------------------------------------------------
// mdom_scdb_hdr_serializer_if
//   Word stream between the header serializer and its downstream sink.
//
//   wr_ready  sink -> source  sink accepts wr_data this cycle
//   wr_valid  source -> sink  wr_data holds a valid header word
//   wr_data   source -> sink  16-bit serialized header word
//   wr_first  source -> sink  marks word 0 of a header
//   wr_last   source -> sink  marks word 7 of a header
//
//   master : serializer side
//   slave  : sink side
// ---------------------------------------------------------------------------
interface mdom_scdb_hdr_serializer_if;
  logic        wr_ready;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_first;
  logic        wr_last;

  modport master (
    input  wr_ready,
    output wr_valid,
    output wr_data,
    output wr_first,
    output wr_last
  );

  modport slave (
    output wr_ready,
    input  wr_valid,
    input  wr_data,
    input  wr_first,
    input  wr_last
  );
endinterface

// File: rtl/mdom_scdb_hdr_serializer.sv
// ---------------------------------------------------------------------------
// mdom_scdb_hdr_serializer
//   Pops 111-bit header bundles from a show-ahead FIFO and emits each one
//   as eight 16-bit words on a valid/ready stream.
//     word 0    : {HDR_MARKER, 3'b000, channel_idx}
//     word 1..7 : 16-bit slices of {1'b0, bundle}, least significant first
//
//   Parameters
//     HDR_MARKER      marker byte placed in word 0
//
//   Ports
//     clk             rising-edge clock
//     rst_n           synchronous active-low reset
//     en              fetch enable; only gates the start of a new header
//     hdr_fifo_empty  header FIFO empty flag
//     hdr_fifo_dout   head-of-FIFO header bundle
//     hdr_fifo_rd_en  one-cycle pop strobe per header
//     wr              word stream (master side)
//     busy            a header is held or being sent
//     hdr_cnt         number of headers fully sent (wraps)
// ---------------------------------------------------------------------------
module mdom_scdb_hdr_serializer #(
  parameter logic [7:0] HDR_MARKER = 8'hA5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               hdr_fifo_empty,
  input  logic [110:0]                       hdr_fifo_dout,
  output logic                               hdr_fifo_rd_en,
  mdom_scdb_hdr_serializer_if.master         wr,
  output logic                               busy,
  output logic [31:0]                        hdr_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [110:0]  shadow_q;
  logic          load;
  logic          cnt_inc;
  logic          accept;
  logic          can_fetch;
  logic [111:0]  payload;
  logic [15:0]   word;

  assign can_fetch = en & ~hdr_fifo_empty;
  assign accept    = (state_q == SEND) & wr.wr_ready;
  assign payload   = {1'b0, shadow_q};

  // Next-state / control. A pop happens either from IDLE or on the same
  // cycle word 7 is accepted, so consecutive headers leave no idle cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    load    = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_fetch) begin
          load    = 1'b1;
          k_d     = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (k_q == 3'd7) begin
            cnt_inc = 1'b1;
            k_d     = '0;
            if (can_fetch) begin
              load    = 1'b1;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // The pop strobe must stay low while reset is held, even though the
  // registered state already reads IDLE during that cycle.
  assign hdr_fifo_rd_en = load & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      shadow_q <= '0;
      hdr_cnt  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (load) begin
        shadow_q <= hdr_fifo_dout;
      end
      if (cnt_inc) begin
        hdr_cnt <= hdr_cnt + 32'd1;
      end
    end
  end

  // Word select purely from held state, so the word is stable under
  // backpressure and independent of the FIFO head.
  always_comb begin
    word = '0;
    unique case (k_q)
      3'd0: word = {HDR_MARKER, 3'b000, shadow_q[110:106]};
      3'd1: word = payload[15:0];
      3'd2: word = payload[31:16];
      3'd3: word = payload[47:32];
      3'd4: word = payload[63:48];
      3'd5: word = payload[79:64];
      3'd6: word = payload[95:80];
      3'd7: word = payload[111:96];
      default: word = '0;
    endcase
  end

  always_comb begin
    wr.wr_valid = (state_q == SEND);
    wr.wr_data  = wr.wr_valid ? word : 16'h0000;
    wr.wr_first = wr.wr_valid & (k_q == 3'd0);
    wr.wr_last  = wr.wr_valid & (k_q == 3'd7);
    busy        = (state_q == SEND);
  end

endmodule

// File: tb/tb_mdom_scdb_hdr_serializer.sv
module tb_mdom_scdb_hdr_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         hdr_fifo_empty;
  logic [110:0] hdr_fifo_dout;
  logic         hdr_fifo_rd_en;
  logic         busy;
  logic [31:0]  hdr_cnt;

  mdom_scdb_hdr_serializer_if wr_if ();

  mdom_scdb_hdr_serializer #(.HDR_MARKER(8'hA5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .hdr_fifo_empty (hdr_fifo_empty),
    .hdr_fifo_dout  (hdr_fifo_dout),
    .hdr_fifo_rd_en (hdr_fifo_rd_en),
    .wr             (wr_if),
    .busy           (busy),
    .hdr_cnt        (hdr_cnt)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [110:0] fifo_mem [8];
  logic [3:0]   wr_ptr = '0;
  logic [3:0]   rd_ptr = '0;
  int           pops = 0;
  int           viol = 0;

  assign hdr_fifo_empty = (rd_ptr == wr_ptr);
  assign hdr_fifo_dout  = fifo_mem[rd_ptr[2:0]];

  always @(posedge clk) begin
    if (hdr_fifo_rd_en) begin
      if (hdr_fifo_empty) viol++;
      else rd_ptr <= rd_ptr + 4'd1;
      pops++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [110:0] b);
    fifo_mem[wr_ptr[2:0]] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Checks one header word by word; stall_k/drop_k/abort_k = 8 means unused.
  task automatic send_hdr(input logic [7:0][15:0] w, input int stall_k,
                          input int drop_k, input int abort_k);
    for (int k = 0; k < 8; k++) begin
      check("wr_valid", 32'(wr_if.wr_valid), 32'd1);
      check("wr_data",  32'(wr_if.wr_data),  32'(w[k]));
      check("wr_first", 32'(wr_if.wr_first), 32'(k == 0));
      check("wr_last",  32'(wr_if.wr_last),  32'(k == 7));
      if (k == stall_k) begin
        wr_if.wr_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_valid", 32'(wr_if.wr_valid), 32'd1);
          check("stall_data",  32'(wr_if.wr_data),  32'(w[k]));
          check("stall_first", 32'(wr_if.wr_first), 32'(k == 0));
        end
        wr_if.wr_ready = 1'b1;
      end
      if (k == drop_k) en = 1'b0;
      if (k == abort_k) begin
        rst_n = 1'b0;
        tick();
        return;
      end
      tick();
    end
  endtask

  logic [110:0]      h1, h2, h3;
  logic [7:0][15:0]  h1w, h2w, h3w;
  int                p0;

  initial begin
    h1 = {5'd19, 57'd0, 49'h1_2345_6789_ABCD};
    h1w = {16'h4C00, 16'h0000, 16'h0000, 16'h0001,
           16'h2345, 16'h6789, 16'hABCD, 16'hA513};
    h2 = '1;
    h2w = {16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hA51F};
    h3 = '0;
    h3[59:49]  = 11'h7FF;
    h3[72:71]  = 2'b10;
    h3[102]    = 1'b1;
    h3w = {16'h0040, 16'h0000, 16'h0100, 16'h0FFE,
           16'h0000, 16'h0000, 16'h0000, 16'hA500};

    rst_n = 1'b0;
    en = 1'b1;
    wr_if.wr_ready = 1'b1;
    push(h1);
    tick();
    tick();
    // Reset state, with a pending header and en high
    check("rst_rd_en",  32'(hdr_fifo_rd_en), 32'd0);
    check("rst_valid",  32'(wr_if.wr_valid), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_data",   32'(wr_if.wr_data), 32'd0);
    check("rst_first",  32'(wr_if.wr_first), 32'd0);
    check("rst_last",   32'(wr_if.wr_last), 32'd0);
    check("rst_cnt",    hdr_cnt, 32'd0);

    // Single header, exact one-cycle latency from pop to word 0
    rst_n = 1'b1;
    #1;
    check("t1_rd_en", 32'(hdr_fifo_rd_en), 32'd1);
    check("t1_busy0", 32'(busy), 32'd0);
    tick();
    send_hdr(h1w, 8, 8, 8);
    check("t1_cnt",   hdr_cnt, 32'd1);
    check("t1_idle",  32'(busy), 32'd0);
    check("t1_valid", 32'(wr_if.wr_valid), 32'd0);
    check("t1_rd_en_empty", 32'(hdr_fifo_rd_en), 32'd0);

    // Backpressure at word 2
    push(h1);
    #1;
    check("t2_rd_en", 32'(hdr_fifo_rd_en), 32'd1);
    tick();
    send_hdr(h1w, 2, 8, 8);
    check("t2_cnt", hdr_cnt, 32'd2);

    // Back-to-back: three queued headers, 24 consecutive words
    en = 1'b0;
    push(h2);
    push(h3);
    push(h1);
    tick();
    check("t3_en_low_rd_en", 32'(hdr_fifo_rd_en), 32'd0);
    check("t3_en_low_busy",  32'(busy), 32'd0);
    p0 = pops;
    en = 1'b1;
    tick();
    send_hdr(h2w, 8, 8, 8);
    send_hdr(h3w, 8, 8, 8);
    send_hdr(h1w, 8, 8, 8);
    check("t3_pops", 32'(pops - p0), 32'd3);
    check("t3_cnt",  hdr_cnt, 32'd5);
    check("t3_busy", 32'(busy), 32'd0);

    // en dropped at word 4 with FIFO non-empty
    en = 1'b0;
    push(h2);
    push(h3);
    en = 1'b1;
    #1;
    check("t4_rd_en", 32'(hdr_fifo_rd_en), 32'd1);
    tick();
    send_hdr(h2w, 8, 4, 8);
    check("t4_busy",  32'(busy), 32'd0);
    check("t4_rd_en_off", 32'(hdr_fifo_rd_en), 32'd0);
    check("t4_cnt",   hdr_cnt, 32'd6);
    p0 = pops;
    tick();
    tick();
    tick();
    check("t4_no_pop", 32'(pops - p0), 32'd0);
    check("t4_still_idle", 32'(busy), 32'd0);
    en = 1'b1;
    #1;
    check("t4_rd_en_again", 32'(hdr_fifo_rd_en), 32'd1);
    tick();
    send_hdr(h3w, 8, 8, 8);
    check("t4_cnt2", hdr_cnt, 32'd7);

    // Reset at word 3; held header is dropped, next one starts at word 0
    push(h1);
    push(h2);
    #1;
    check("t5_rd_en", 32'(hdr_fifo_rd_en), 32'd1);
    tick();
    send_hdr(h1w, 8, 8, 3);
    check("t5_valid", 32'(wr_if.wr_valid), 32'd0);
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_data",  32'(wr_if.wr_data), 32'd0);
    check("t5_first", 32'(wr_if.wr_first), 32'd0);
    check("t5_last",  32'(wr_if.wr_last), 32'd0);
    check("t5_cnt",   hdr_cnt, 32'd0);
    check("t5_rd_en_in_rst", 32'(hdr_fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    #1;
    check("t5_rd_en_rel", 32'(hdr_fifo_rd_en), 32'd1);
    tick();
    send_hdr(h2w, 8, 8, 8);
    check("t5_cnt2", hdr_cnt, 32'd1);
    check("t5_busy2", 32'(busy), 32'd0);

    // Counter wrap
    force dut.hdr_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.hdr_cnt;
    #1;
    check("t6_preload", hdr_cnt, 32'hFFFF_FFFF);
    push(h3);
    tick();
    send_hdr(h3w, 8, 8, 8);
    check("t6_wrap", hdr_cnt, 32'd0);

    check("pop_while_empty", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
